alu_ctrl_unit: RTL and testbench

//  Control unit that issues operations to the ALU and consumes its results.

---
 rtl/alu_cu_defs.sv | 45 ++++
 rtl/cu_regfile.sv | 41 ++++
 rtl/alu_ctrl_unit.sv | 139 +++++++++++++
 tb/tb_alu_ctrl_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cu_defs.sv
// Shared definitions for the ALU control unit: opcodes, FSM encoding,
// instruction field positions and opcode classification helpers.
package alu_cu_defs;

    localparam int CU_DATA_W = 32;
    localparam int CU_NREGS  = 8;
    localparam int CU_REG_AW = 3;
    localparam int OP_W      = 6;

    localparam int OP_LO  = 26;
    localparam int RD_LO  = 23;
    localparam int RS1_LO = 20;
    localparam int RS2_LO = 17;
    localparam int IMM_W  = 16;

    localparam logic [OP_W-1:0] OP_NOP = 6'b000000;
    localparam logic [OP_W-1:0] OP_LDI = 6'b000001;
    localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
    localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
    localparam logic [OP_W-1:0] OP_NE  = 6'b100001;
    localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
    localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
    localparam logic [OP_W-1:0] OP_SLL = 6'b110000;
    localparam logic [OP_W-1:0] OP_SRL = 6'b110001;
    localparam logic [OP_W-1:0] OP_SRA = 6'b110010;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
            OP_SLL, OP_SRL, OP_SRA: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Only arithmetic ops define a carry/borrow; compares and shifts keep C.
    function automatic logic sets_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file for the control unit: one write port, two read ports sampled
// by the caller at DECODE, one combinational debug port; r0 is hard zero.
module cu_regfile
    import alu_cu_defs::*;
#(
    parameter int DATA_W = CU_DATA_W,
    parameter int NREGS  = CU_NREGS,
    parameter int REG_AW = CU_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREGS];

    // NOTE: the array is built from flops and must read zero after reset, so it
    // is reset explicitly; a RAM macro could not be used here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : regs[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl_unit.sv
// ALU control unit: accepts one instruction per handshake, reads operands,
// drives an external ALU and writes its result and flags back.
module alu_ctrl_unit
    import alu_cu_defs::*;
#(
    parameter int DATA_W = CU_DATA_W,
    parameter int NREGS  = CU_NREGS,
    parameter int REG_AW = CU_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [1:0]        state;
    logic [31:0]       instr_q;
    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              unused_instr_bit;

    assign op_q    = instr_q[OP_LO +: OP_W];
    assign rd_q    = instr_q[RD_LO +: REG_AW];
    assign rs1_q   = instr_q[RS1_LO +: REG_AW];
    assign rs2_q   = instr_q[RS2_LO +: REG_AW];
    assign imm_ext = {{(DATA_W-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
    assign unused_instr_bit = instr_q[16];

    assign instr_ready = (state == ST_IDLE);

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        we    = 1'b0;
        wdata = alu_res;
        if (state == ST_EXEC) begin
            if (is_alu_op(op_q)) begin
                we = 1'b1;
            end else if (op_q == OP_LDI) begin
                we    = 1'b1;
                wdata = imm_ext;
            end
        end
    end

    cu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (rd_q),
        .wdata    (wdata),
        .raddr_a  (rs1_q),
        .rdata_a  (rdata_a),
        .raddr_b  (rs2_q),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            instr_q <= '0;
            alu_op  <= OP_NOP;
            alu_a   <= '0;
            alu_b   <= '0;
            result  <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_a  <= rdata_a;
                    alu_b  <= rdata_b;
                    alu_op <= is_alu_op(op_q) ? op_q : OP_NOP;
                    state  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_alu_op(op_q)) begin
                        result <= alu_res;
                        flag_z <= alu_z;
                        flag_n <= alu_n;
                        if (sets_carry(op_q)) begin
                            flag_c <= alu_cout;
                        end
                    end else if (op_q == OP_LDI) begin
                        result <= imm_ext;
                    end else if (op_q != OP_NOP) begin
                        err <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed testbench for alu_ctrl_unit; the ALU is played by the bench,
// which drives fixed result/flag values for each instruction.
module tb_alu_ctrl_unit;
    import alu_cu_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic        flag_c, flag_z, flag_n;
    logic [5:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_res;
    logic        alu_cout, alu_z, alu_n;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int tests  = 0;
    int failed = 0;

    logic [31:0] cap_a, cap_b;
    logic [5:0]  cap_op;

    always #5 clk = ~clk;

    alu_ctrl_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .done        (done),
        .err         (err),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_res     (alu_res),
        .alu_cout    (alu_cout),
        .alu_z       (alu_z),
        .alu_n       (alu_n),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm);
        return {op, rd, rs1, rs2, 1'b0, imm};
    endfunction

    task automatic set_alu(input logic [31:0] res, input logic c, input logic z, input logic n);
        alu_res = res; alu_cout = c; alu_z = z; alu_n = n;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
        dbg_addr = a;
        #1 d = dbg_data;
    endtask

    // Issues one instruction and follows it to retirement: accept edge,
    // DECODE->EXEC edge, EXEC->IDLE edge (done set), then done clears.
    task automatic issue(input logic [31:0] i, input logic exp_err, input string name);
        @(negedge clk);
        instr = i; instr_valid = 1'b1;
        tests++;
        if (instr_ready !== 1'b1) begin
            failed++; $display("FAIL %s ready_idle: got %b want 1", name, instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        tests++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL %s decode: ready=%b done=%b want 0 0", name, instr_ready, done);
        end
        @(negedge clk);
        cap_a = alu_a; cap_b = alu_b; cap_op = alu_op;
        tests++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            failed++; $display("FAIL %s exec: ready=%b done=%b want 0 0", name, instr_ready, done);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== exp_err || instr_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s retire: done=%b err=%b ready=%b want 1 %b 1", name, done, err, instr_ready, exp_err);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || err !== 1'b0) begin
            failed++; $display("FAIL %s pulse_width: done=%b err=%b want 0 0", name, done, err);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        saw_done;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || result !== 32'h0 ||
            {flag_c, flag_z, flag_n} !== 3'b000 || alu_op !== 6'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            failed++; $display("FAIL reset_initial: ready=%b result=%h flags=%b op=%h", instr_ready, result, {flag_c, flag_z, flag_n}, alu_op);
        end
        rst = 1'b0;
        // Make state non-trivial before the mid-EXEC reset.
        issue(mk(OP_LDI, 3'd5, 3'd0, 3'd0, 16'h1234), 1'b0, "rst_ldi");
        set_alu(32'h2468, 1'b1, 1'b0, 1'b1);
        issue(mk(OP_ADD, 3'd7, 3'd5, 3'd5, 16'h0), 1'b0, "rst_add");
        tests++;
        if (result !== 32'h2468 || {flag_c, flag_z, flag_n} !== 3'b101) begin
            failed++; $display("FAIL rst_add_wb: result=%h flags=%b want 00002468 101", result, {flag_c, flag_z, flag_n});
        end
        @(negedge clk);
        instr = mk(OP_LDI, 3'd6, 3'd0, 3'd0, 16'h00AA); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || result !== 32'h0 ||
            {flag_c, flag_z, flag_n} !== 3'b000 || alu_op !== 6'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            failed++; $display("FAIL reset_mid_exec: ready=%b result=%h flags=%b a=%h b=%h", instr_ready, result, {flag_c, flag_z, flag_n}, alu_a, alu_b);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            failed++; $display("FAIL reset_no_done: got done pulse, want none");
        end
        for (int r = 0; r < 8; r++) begin
            read_reg(r[2:0], d);
            tests++;
            if (d !== 32'h0) begin
                failed++; $display("FAIL reset_reg%0d: got %h want 00000000", r, d);
            end
        end
    endtask

    task automatic test_ldi_add();
        logic [31:0] d;
        set_alu(32'h0, 1'b0, 1'b0, 1'b0);
        issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0011), 1'b0, "ldi_r1");
        issue(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001), 1'b0, "ldi_r2");
        tests++;
        if (result !== 32'h1 || cap_op !== OP_NOP) begin
            failed++; $display("FAIL ldi_result: result=%h op=%h want 00000001 00", result, cap_op);
        end
        issue(mk(OP_LDI, 3'd7, 3'd0, 3'd0, 16'h8000), 1'b0, "ldi_neg");
        read_reg(3'd7, d);
        tests++;
        if (d !== 32'hFFFF8000 || result !== 32'hFFFF8000) begin
            failed++; $display("FAIL ldi_sign_ext: reg=%h result=%h want ffff8000", d, result);
        end
        set_alu(32'h12, 1'b0, 1'b0, 1'b0);
        issue(mk(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0), 1'b0, "add");
        tests++;
        if (cap_a !== 32'h11 || cap_b !== 32'h1 || cap_op !== OP_ADD) begin
            failed++; $display("FAIL add_drive: a=%h b=%h op=%b want 00000011 00000001 010000", cap_a, cap_b, cap_op);
        end
        read_reg(3'd3, d);
        tests++;
        if (d !== 32'h12 || result !== 32'h12 || flag_z !== 1'b0) begin
            failed++; $display("FAIL add_wb: reg3=%h result=%h z=%b want 00000012 00000012 0", d, result, flag_z);
        end
    endtask

    task automatic test_sub();
        logic [31:0] d;
        issue(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF), 1'b0, "ldi_ffff");
        read_reg(3'd1, d);
        tests++;
        if (d !== 32'hFFFFFFFF) begin
            failed++; $display("FAIL ldi_ffff: got %h want ffffffff", d);
        end
        set_alu(32'h0, 1'b0, 1'b1, 1'b0);
        issue(mk(OP_SUB, 3'd4, 3'd1, 3'd1, 16'h0), 1'b0, "sub");
        tests++;
        if (cap_a !== 32'hFFFFFFFF || cap_b !== 32'hFFFFFFFF || cap_op !== OP_SUB) begin
            failed++; $display("FAIL sub_drive: a=%h b=%h op=%b", cap_a, cap_b, cap_op);
        end
        read_reg(3'd4, d);
        tests++;
        if (d !== 32'h0 || {flag_c, flag_z, flag_n} !== 3'b010) begin
            failed++; $display("FAIL sub_wb: reg4=%h flags(czn)=%b want 00000000 010", d, {flag_c, flag_z, flag_n});
        end
    endtask

    task automatic test_carry_hold();
        logic [31:0] d;
        set_alu(32'h0, 1'b1, 1'b1, 1'b0);
        issue(mk(OP_ADD, 3'd5, 3'd1, 3'd2, 16'h0), 1'b0, "add_carry");
        tests++;
        if ({flag_c, flag_z, flag_n} !== 3'b110) begin
            failed++; $display("FAIL add_carry: flags=%b want 110", {flag_c, flag_z, flag_n});
        end
        set_alu(32'h80000000, 1'b0, 1'b0, 1'b1);
        issue(mk(OP_SLL, 3'd6, 3'd2, 3'd2, 16'h0), 1'b0, "sll");
        read_reg(3'd6, d);
        tests++;
        if (cap_op !== OP_SLL || d !== 32'h80000000 || {flag_c, flag_z, flag_n} !== 3'b101) begin
            failed++; $display("FAIL sll_hold_c: op=%b reg6=%h flags=%b want 110000 80000000 101", cap_op, d, {flag_c, flag_z, flag_n});
        end
        set_alu(32'h77, 1'b0, 1'b0, 1'b0);
        issue(mk(OP_ADD, 3'd0, 3'd2, 3'd2, 16'h0), 1'b0, "add_r0");
        read_reg(3'd0, d);
        tests++;
        if (d !== 32'h0 || result !== 32'h77 || flag_c !== 1'b0) begin
            failed++; $display("FAIL add_r0: reg0=%h result=%h c=%b want 00000000 00000077 0", d, result, flag_c);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] d;
        set_alu(32'h5, 1'b0, 1'b0, 1'b0);
        issue(mk(OP_ADD, 3'd1, 3'd1, 3'd2, 16'h0), 1'b0, "rd_eq_rs1");
        read_reg(3'd1, d);
        tests++;
        if (cap_a !== 32'hFFFFFFFF || cap_b !== 32'h1 || d !== 32'h5) begin
            failed++; $display("FAIL rd_eq_rs1: a=%h b=%h reg1=%h want ffffffff 00000001 00000005", cap_a, cap_b, d);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] d;
        set_alu(32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        issue(mk(6'b111111, 3'd3, 3'd1, 3'd2, 16'h0), 1'b1, "illegal_3f");
        read_reg(3'd3, d);
        tests++;
        if (d !== 32'h12 || result !== 32'h5 || {flag_c, flag_z, flag_n} !== 3'b000 || cap_op !== 6'h0) begin
            failed++; $display("FAIL illegal_3f_state: reg3=%h result=%h flags=%b op=%h want 00000012 00000005 000 00", d, result, {flag_c, flag_z, flag_n}, cap_op);
        end
        issue(mk(6'b010010, 3'd2, 3'd1, 3'd1, 16'h0), 1'b1, "illegal_12");
        read_reg(3'd2, d);
        tests++;
        if (d !== 32'h1 || result !== 32'h5) begin
            failed++; $display("FAIL illegal_12_state: reg2=%h result=%h want 00000001 00000005", d, result);
        end
        issue(mk(OP_NOP, 3'd2, 3'd1, 3'd1, 16'h0), 1'b0, "nop");
        read_reg(3'd2, d);
        tests++;
        if (d !== 32'h1 || result !== 32'h5 || {flag_c, flag_z, flag_n} !== 3'b000) begin
            failed++; $display("FAIL nop_state: reg2=%h result=%h flags=%b", d, result, {flag_c, flag_z, flag_n});
        end
    endtask

    // Valid held high over 9 clock edges: accepts land on edges 0, 3 and 6.
    task automatic test_back_to_back();
        int accepts;
        int acc_edge [3];
        accepts = 0;
        @(negedge clk);
        instr = mk(OP_NOP, 3'd0, 3'd0, 3'd0, 16'h0);
        instr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (instr_ready === 1'b1) begin
                if (accepts < 3) acc_edge[accepts] = k;
                accepts++;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        tests++;
        if (accepts !== 3) begin
            failed++; $display("FAIL b2b_count: got %0d accepts want 3", accepts);
        end else begin
            tests++;
            if (acc_edge[0] !== 0 || acc_edge[1] !== 3 || acc_edge[2] !== 6) begin
                failed++; $display("FAIL b2b_spacing: edges %0d %0d %0d want 0 3 6", acc_edge[0], acc_edge[1], acc_edge[2]);
            end
        end
        tests++;
        if (done !== 1'b1 || instr_ready !== 1'b1) begin
            failed++; $display("FAIL b2b_last_done: done=%b ready=%b want 1 1", done, instr_ready);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        set_alu(32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_ldi_add();
        test_sub();
        test_carry_hold();
        test_hazard();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
